mac_seq_ctrl: RTL

- Sequences one dot-product job onto the shared pipelined floating-point MAC: Y = sum(A[i]*B[i]), i = 0..len-1.
- Accepts a job command and a valid/ready operand stream, and issues one element at a time to the MAC.
- Tracks each in-flight element with a latency shift register, feeds the running sum back as the MAC Y input, and returns the final IEEE-754 single result on a valid/ready port.
- Sits between the operand fetch logic and the MAC datapath (multiplier, Y delay buffer, adder).

---
 rtl/mac_seq_ctrl_pkg.sv | 15 +
 rtl/mac_issue_tracker.sv | 29 ++
 rtl/mac_seq_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared encodings and defaults for the dot-product sequencer that drives the pipelined FP MAC.
package mac_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] FP_ZERO         = 32'h0000_0000;
    localparam int          DEFAULT_MAC_LAT = 20;
    localparam int          DEFAULT_LEN_W   = 8;

endpackage

// File: rtl/mac_issue_tracker.sv
// One valid bit per MAC pipeline stage; the tail marks the cycle the matching mac_z is valid.
module mac_issue_tracker #(
    parameter int MAC_LAT = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic launch,
    output logic tail,
    output logic any_inflight
);

    logic [MAC_LAT-1:0] bits;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            bits <= '0;
        end else begin
            bits <= {bits[MAC_LAT-2:0], launch};
        end
    end

    assign tail         = bits[MAC_LAT-1];
    assign any_inflight = |bits;

    // The feedback dependency allows only one element in flight at a time.
    tracker_single_inflight: assert property (@(posedge clock) disable iff (reset) $onehot0(bits));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Issues one dot-product job element by element to the shared FP MAC, feeding the running sum back as Y.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int MAC_LAT = DEFAULT_MAC_LAT,
    parameter int LEN_W   = DEFAULT_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             mac_issue,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic [31:0]      mac_y,
    input  logic [31:0]      mac_z,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      acc;
    logic             first;
    logic             cmd_fire;
    logic             op_fire;
    logic             tail;
    logic             any_inflight;

    assign cmd_fire = (state == IDLE) && cmd_valid;
    assign op_fire  = (state == ISSUE) && op_valid;

    mac_issue_tracker #(
        .MAC_LAT(MAC_LAT)
    ) u_tracker (
        .clock       (clock),
        .reset       (reset),
        .launch      (op_fire),
        .tail        (tail),
        .any_inflight(any_inflight)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = (cmd_len == '0) ? DONE : ISSUE;
            ISSUE:   if (op_valid) state_next = WAIT;
            WAIT:    if (tail) state_next = (remaining == '0) ? DONE : ISSUE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ISSUE:   op_ready = 1'b1;
            DONE:    res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mac_issue <= 1'b0;
            mac_a     <= FP_ZERO;
            mac_b     <= FP_ZERO;
            mac_y     <= FP_ZERO;
            res_data  <= FP_ZERO;
            remaining <= '0;
            acc       <= FP_ZERO;
            first     <= 1'b0;
        end else begin
            mac_issue <= op_fire;
            if (cmd_fire) begin
                remaining <= cmd_len;
                acc       <= FP_ZERO;
                first     <= 1'b1;
                if (cmd_len == '0) begin
                    res_data <= FP_ZERO;
                end
            end
            if (op_fire) begin
                mac_a <= op_a;
                mac_b <= op_b;
                mac_y <= first ? FP_ZERO : acc;
                first <= 1'b0;
                if (remaining != '0) begin
                    remaining <= remaining - LEN_W'(1);
                end
            end
            // The tail bit is the only moment mac_z belongs to this job.
            if ((state == WAIT) && tail) begin
                acc <= mac_z;
                if (remaining == '0) begin
                    res_data <= mac_z;
                end
            end
        end
    end

    no_back_to_back_issue: assert property (@(posedge clock) disable iff (reset) mac_issue |=> !mac_issue);
    wait_has_inflight: assert property (@(posedge clock) disable iff (reset) (state == WAIT) |-> any_inflight);

endmodule
